// File: rtl/csr_pkg.sv
// Shared constants, encodings and mstatus helpers for the CSR control stage.
package csr_pkg;

   localparam int CSR_XLEN = 32;
   localparam int CSR_ADDR_W = 12;

   localparam logic [11:0] MSTATUS = 12'h300;
   localparam logic [11:0] MTVEC   = 12'h305;
   localparam logic [11:0] MEPC    = 12'h341;
   localparam logic [11:0] MCAUSE  = 12'h342;
   localparam logic [11:0] MTVAL   = 12'h343;
   localparam logic [11:0] MHARTID = 12'hF14;

   localparam int MIE_B  = 3;
   localparam int MPIE_B = 7;
   localparam int MPP_HI = 12;
   localparam int MPP_LO = 11;

   typedef enum logic [1:0] {
      OP_NOP = 2'b00,
      OP_RW  = 2'b01,
      OP_RS  = 2'b10,
      OP_RC  = 2'b11
   } csr_op_e;

   typedef enum logic [3:0] {
      S_IDLE,
      S_ACC,
      S_T_EPC,
      S_T_CAUSE,
      S_T_TVAL,
      S_T_STAT,
      S_T_VEC,
      S_M_STAT,
      S_M_EPC
   } state_e;

   function automatic logic [CSR_XLEN-1:0] trap_mstatus(
      input logic [CSR_XLEN-1:0] old
   );
      logic [CSR_XLEN-1:0] v;
      v = old;
      v[MPIE_B] = old[MIE_B];
      v[MIE_B] = 1'b0;
      v[MPP_HI:MPP_LO] = 2'b11;
      return v;
   endfunction

   function automatic logic [CSR_XLEN-1:0] mret_mstatus(
      input logic [CSR_XLEN-1:0] old
   );
      logic [CSR_XLEN-1:0] v;
      v = old;
      v[MIE_B] = old[MPIE_B];
      v[MPIE_B] = 1'b1;
      v[MPP_HI:MPP_LO] = 2'b11;
      return v;
   endfunction

endpackage

// File: rtl/csr_ctrl_if.sv
// Execute-side request/response and CSR-file bus of the CSR control stage.
interface csr_ctrl_if #(
   parameter int XLEN = 32,
   parameter int ADDR_W = 12
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        req_op;
   logic [ADDR_W-1:0] req_addr;
   logic [XLEN-1:0]   req_src;
   logic              req_src_zero;
   logic              req_rd_zero;
   logic              trap_req;
   logic [XLEN-1:0]   trap_cause;
   logic [XLEN-1:0]   trap_pc;
   logic [XLEN-1:0]   trap_tval;
   logic              mret_req;
   logic              rsp_valid;
   logic [XLEN-1:0]   rsp_data;
   logic              rsp_illegal;
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;
   logic              csr_rd;
   logic              csr_wr;
   logic [ADDR_W-1:0] rd_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic [XLEN-1:0]   wr_dat;
   logic [XLEN-1:0]   rd_dat;

   modport master (
      output req_valid, req_op, req_addr, req_src,
      output req_src_zero, req_rd_zero,
      output trap_req, trap_cause, trap_pc, trap_tval,
      output mret_req, rd_dat,
      input  req_ready, rsp_valid, rsp_data, rsp_illegal,
      input  redirect_valid, redirect_pc,
      input  csr_rd, csr_wr, rd_addr, wr_addr, wr_dat
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_src,
      input  req_src_zero, req_rd_zero,
      input  trap_req, trap_cause, trap_pc, trap_tval,
      input  mret_req, rd_dat,
      output req_ready, rsp_valid, rsp_data, rsp_illegal,
      output redirect_valid, redirect_pc,
      output csr_rd, csr_wr, rd_addr, wr_addr, wr_dat
   );
endinterface

// File: rtl/csr_alu.sv
// Zicsr modify path: computes the new CSR value and whether the write
// goes ahead, is suppressed, or is an illegal write to a read-only CSR.
module csr_alu
   import csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  csr_op_e         op,
   input  logic [XLEN-1:0] old_val,
   input  logic [XLEN-1:0] src,
   input  logic            src_zero,
   input  logic            ro,
   output logic [XLEN-1:0] new_val,
   output logic            wr_en,
   output logic            illegal
);

   logic attempt;

   always_comb begin
      new_val = src;
      attempt = 1'b0;
      unique case (op)
         OP_RW: begin
            new_val = src;
            attempt = 1'b1;
         end
         OP_RS: begin
            new_val = old_val | src;
            attempt = !src_zero;
         end
         OP_RC: begin
            new_val = old_val & ~src;
            attempt = !src_zero;
         end
         default: begin
            new_val = src;
            attempt = 1'b0;
         end
      endcase
      wr_en = attempt && !ro;
      illegal = attempt && ro;
   end

endmodule

// File: rtl/csr_ctrl.sv
// Sequences Zicsr read-modify-write, trap entry and mret onto the
// single-read/single-write machine-mode CSR file.
module csr_ctrl
   import csr_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int ADDR_W = 12
) (
   input logic    clk,
   input logic    reset,
   csr_ctrl_if.slave bus
);

   state_e            state_q, state_d;
   csr_op_e           op_q, op_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [XLEN-1:0]   src_q, src_d;
   logic              src_zero_q, src_zero_d;
   logic              rd_zero_q, rd_zero_d;
   logic [XLEN-1:0]   cause_q, cause_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   tval_q, tval_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_illegal_q, rsp_illegal_d;
   logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
   logic              redir_valid_q, redir_valid_d;
   logic [XLEN-1:0]   redir_pc_q, redir_pc_d;

   logic              rd_c, wr_c;
   logic [ADDR_W-1:0] rd_addr_c, wr_addr_c;
   logic [XLEN-1:0]   wr_dat_c;
   logic [XLEN-1:0]   alu_new;
   logic              alu_wr_en, alu_illegal;
   logic              ro;

   assign ro = (addr_q[ADDR_W-1:ADDR_W-2] == 2'b11);

   csr_alu #(.XLEN(XLEN)) u_alu (
      .op       (op_q),
      .old_val  (bus.rd_dat),
      .src      (src_q),
      .src_zero (src_zero_q),
      .ro       (ro),
      .new_val  (alu_new),
      .wr_en    (alu_wr_en),
      .illegal  (alu_illegal)
   );

   always_comb begin
      state_d = state_q;
      op_d = op_q;
      addr_d = addr_q;
      src_d = src_q;
      src_zero_d = src_zero_q;
      rd_zero_d = rd_zero_q;
      cause_d = cause_q;
      pc_d = pc_q;
      tval_d = tval_q;
      rsp_valid_d = 1'b0;
      rsp_illegal_d = 1'b0;
      rsp_data_d = rsp_data_q;
      redir_valid_d = 1'b0;
      redir_pc_d = redir_pc_q;
      rd_c = 1'b0;
      wr_c = 1'b0;
      rd_addr_c = addr_q;
      wr_addr_c = addr_q;
      wr_dat_c = '0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.trap_req) begin
               cause_d = bus.trap_cause;
               pc_d = bus.trap_pc;
               tval_d = bus.trap_tval;
               state_d = S_T_EPC;
            end else if (bus.mret_req) begin
               state_d = S_M_STAT;
            end else if (bus.req_valid) begin
               op_d = csr_op_e'(bus.req_op);
               addr_d = bus.req_addr;
               src_d = bus.req_src;
               src_zero_d = bus.req_src_zero;
               rd_zero_d = bus.req_rd_zero;
               state_d = S_ACC;
            end
         end
         S_ACC: begin
            rd_c = !(op_q == OP_RW && rd_zero_q);
            wr_c = alu_wr_en;
            wr_dat_c = alu_new;
            rsp_valid_d = 1'b1;
            rsp_illegal_d = alu_illegal;
            rsp_data_d = rd_c ? bus.rd_dat : '0;
            state_d = S_IDLE;
         end
         S_T_EPC: begin
            wr_c = 1'b1;
            wr_addr_c = MEPC;
            wr_dat_c = pc_q & ~XLEN'(3);
            state_d = S_T_CAUSE;
         end
         S_T_CAUSE: begin
            wr_c = 1'b1;
            wr_addr_c = MCAUSE;
            wr_dat_c = cause_q;
            state_d = S_T_TVAL;
         end
         S_T_TVAL: begin
            wr_c = 1'b1;
            wr_addr_c = MTVAL;
            wr_dat_c = tval_q;
            state_d = S_T_STAT;
         end
         S_T_STAT: begin
            rd_c = 1'b1;
            wr_c = 1'b1;
            rd_addr_c = MSTATUS;
            wr_addr_c = MSTATUS;
            wr_dat_c = trap_mstatus(bus.rd_dat);
            state_d = S_T_VEC;
         end
         S_T_VEC: begin
            // only direct mode: mode bits are dropped
            rd_c = 1'b1;
            rd_addr_c = MTVEC;
            redir_valid_d = 1'b1;
            redir_pc_d = bus.rd_dat & ~XLEN'(3);
            state_d = S_IDLE;
         end
         S_M_STAT: begin
            rd_c = 1'b1;
            wr_c = 1'b1;
            rd_addr_c = MSTATUS;
            wr_addr_c = MSTATUS;
            wr_dat_c = mret_mstatus(bus.rd_dat);
            state_d = S_M_EPC;
         end
         S_M_EPC: begin
            rd_c = 1'b1;
            rd_addr_c = MEPC;
            redir_valid_d = 1'b1;
            redir_pc_d = bus.rd_dat;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (!reset) begin
         rd_c = 1'b0;
         wr_c = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         op_q <= OP_NOP;
         addr_q <= '0;
         src_q <= '0;
         src_zero_q <= 1'b0;
         rd_zero_q <= 1'b0;
         cause_q <= '0;
         pc_q <= '0;
         tval_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_illegal_q <= 1'b0;
         rsp_data_q <= '0;
         redir_valid_q <= 1'b0;
         redir_pc_q <= '0;
      end else begin
         state_q <= state_d;
         op_q <= op_d;
         addr_q <= addr_d;
         src_q <= src_d;
         src_zero_q <= src_zero_d;
         rd_zero_q <= rd_zero_d;
         cause_q <= cause_d;
         pc_q <= pc_d;
         tval_q <= tval_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_illegal_q <= rsp_illegal_d;
         rsp_data_q <= rsp_data_d;
         redir_valid_q <= redir_valid_d;
         redir_pc_q <= redir_pc_d;
      end
   end

   assign bus.req_ready = (state_q == S_IDLE) && reset;
   assign bus.csr_rd = rd_c;
   assign bus.csr_wr = wr_c;
   assign bus.rd_addr = rd_addr_c;
   assign bus.wr_addr = wr_addr_c;
   assign bus.wr_dat = wr_dat_c;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_illegal = rsp_illegal_q;
   assign bus.rsp_data = rsp_data_q;
   assign bus.redirect_valid = redir_valid_q;
   assign bus.redirect_pc = redir_pc_q;

endmodule

// File: tb/tb_csr_ctrl.sv
// Directed bench: CSR file model plus write/response/redirect scoreboards.
module tb_csr_ctrl;
   import csr_pkg::*;

   typedef struct {
      logic [11:0] a;
      logic [31:0] d;
      int          c;
   } wexp_t;

   typedef struct {
      logic [31:0] d;
      logic        ill;
      int          c;
   } rexp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   logic        pre_en = 1'b0;
   logic [11:0] pre_addr = '0;
   logic [31:0] pre_dat = '0;
   logic [31:0] mem [4096];

   wexp_t wq[$];
   rexp_t rq[$];
   rexp_t xq[$];
   wexp_t w_cur;
   rexp_t r_cur;
   rexp_t x_cur;

   always #5 clk = ~clk;

   csr_ctrl_if #(.XLEN(32), .ADDR_W(12)) ifc ();

   csr_ctrl #(.XLEN(32), .ADDR_W(12)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   assign ifc.rd_dat = mem[ifc.rd_addr];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ifc.csr_wr) mem[ifc.wr_addr] <= ifc.wr_dat;
      else if (pre_en) mem[pre_addr] <= pre_dat;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (ifc.csr_wr) begin
         chk("wr_expected", 32'(wq.size() != 0), 32'd1);
         if (wq.size() != 0) begin
            w_cur = wq.pop_front();
            chk("wr_addr", 32'(ifc.wr_addr), 32'(w_cur.a));
            chk("wr_dat", ifc.wr_dat, w_cur.d);
            chk("wr_cycle", cyc, w_cur.c);
         end
      end
      if (ifc.rsp_valid) begin
         chk("rsp_expected", 32'(rq.size() != 0), 32'd1);
         if (rq.size() != 0) begin
            r_cur = rq.pop_front();
            chk("rsp_data", ifc.rsp_data, r_cur.d);
            chk("rsp_illegal", 32'(ifc.rsp_illegal), 32'(r_cur.ill));
            chk("rsp_cycle", cyc, r_cur.c);
         end
      end
      if (ifc.redirect_valid) begin
         chk("redir_expected", 32'(xq.size() != 0), 32'd1);
         if (xq.size() != 0) begin
            x_cur = xq.pop_front();
            chk("redir_pc", ifc.redirect_pc, x_cur.d);
            chk("redir_cycle", cyc, x_cur.c);
         end
      end
      if (ifc.rsp_valid || ifc.redirect_valid)
         chk("rsp_redir_excl", 32'(ifc.rsp_valid && ifc.redirect_valid), 32'd0);
   end

   task automatic preset(input logic [11:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      pre_en = 1'b1;
      pre_addr = a;
      pre_dat = d;
      @(posedge clk); #1;
      pre_en = 1'b0;
   endtask

   task automatic drained(input string tag);
      chk({tag, "_wq"}, wq.size(), 0);
      chk({tag, "_rq"}, rq.size(), 0);
      chk({tag, "_xq"}, xq.size(), 0);
   endtask

   task automatic csr_op(input logic [1:0] op, input logic [11:0] a,
                         input logic [31:0] src, input logic sz,
                         input logic rz, input bit wr,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input logic ill, input string tag);
      int n;
      @(posedge clk); #1;
      ifc.req_valid = 1'b1;
      ifc.req_op = op;
      ifc.req_addr = a;
      ifc.req_src = src;
      ifc.req_src_zero = sz;
      ifc.req_rd_zero = rz;
      n = cyc;
      if (wr) wq.push_back('{a, wd, n + 1});
      rq.push_back('{rd, ill, n + 2});
      @(posedge clk); #1;
      ifc.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk({tag, "_ready_n2"}, 32'(ifc.req_ready), 32'd1);
      repeat (3) @(posedge clk);
      drained(tag);
   endtask

   initial begin
      int n;
      ifc.req_valid = 1'b0;
      ifc.req_op = 2'b00;
      ifc.req_addr = '0;
      ifc.req_src = '0;
      ifc.req_src_zero = 1'b0;
      ifc.req_rd_zero = 1'b0;
      ifc.trap_req = 1'b0;
      ifc.trap_cause = '0;
      ifc.trap_pc = '0;
      ifc.trap_tval = '0;
      ifc.mret_req = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 32'(ifc.req_ready), 32'd0);
      chk("rst_csr_rd", 32'(ifc.csr_rd), 32'd0);
      chk("rst_csr_wr", 32'(ifc.csr_wr), 32'd0);
      chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
      chk("rst_redir_valid", 32'(ifc.redirect_valid), 32'd0);
      chk("rst_rsp_data", ifc.rsp_data, 32'd0);
      chk("rst_redir_pc", ifc.redirect_pc, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(ifc.req_ready), 32'd1);

      preset(12'h340, 32'h1234_5678);
      csr_op(2'b01, 12'h340, 32'hDEAD_BEEF, 1'b0, 1'b0,
             1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, "rw");
      chk("rw_mem", mem[12'h340], 32'hDEAD_BEEF);

      csr_op(2'b01, 12'h340, 32'h0000_0005, 1'b0, 1'b1,
             1'b1, 32'h0000_0005, 32'h0, 1'b0, "rw_rd0");

      preset(MSTATUS, 32'h88);
      csr_op(2'b10, MSTATUS, 32'h0, 1'b1, 1'b0,
             1'b0, 32'h0, 32'h88, 1'b0, "rs_z");
      csr_op(2'b11, MSTATUS, 32'h8, 1'b0, 1'b0,
             1'b1, 32'h80, 32'h88, 1'b0, "rc");
      csr_op(2'b10, MSTATUS, 32'h1001, 1'b0, 1'b0,
             1'b1, 32'h1081, 32'h80, 1'b0, "rs");

      preset(MHARTID, 32'h0);
      csr_op(2'b01, MHARTID, 32'h1, 1'b0, 1'b0,
             1'b0, 32'h0, 32'h0, 1'b1, "ro");
      chk("ro_mem", mem[MHARTID], 32'h0);

      preset(MSTATUS, 32'h8);
      preset(MTVEC, 32'h201);
      @(posedge clk); #1;
      ifc.trap_req = 1'b1;
      ifc.trap_cause = 32'hB;
      ifc.trap_pc = 32'h1002;
      ifc.trap_tval = 32'h0;
      n = cyc;
      wq.push_back('{MEPC, 32'h1000, n + 1});
      wq.push_back('{MCAUSE, 32'hB, n + 2});
      wq.push_back('{MTVAL, 32'h0, n + 3});
      wq.push_back('{MSTATUS, 32'h1880, n + 4});
      xq.push_back('{32'h200, 1'b0, n + 6});
      @(posedge clk); #1;
      ifc.trap_req = 1'b0;
      repeat (8) @(posedge clk);
      drained("trap");

      @(posedge clk); #1;
      ifc.mret_req = 1'b1;
      n = cyc;
      wq.push_back('{MSTATUS, 32'h1888, n + 1});
      xq.push_back('{32'h1000, 1'b0, n + 3});
      @(posedge clk); #1;
      ifc.mret_req = 1'b0;
      repeat (6) @(posedge clk);
      drained("mret");

      @(posedge clk); #1;
      ifc.trap_req = 1'b1;
      ifc.trap_cause = 32'h2;
      ifc.trap_pc = 32'h2004;
      ifc.trap_tval = 32'h77;
      ifc.req_valid = 1'b1;
      ifc.req_op = 2'b01;
      ifc.req_addr = 12'h340;
      ifc.req_src = 32'h55;
      n = cyc;
      wq.push_back('{MEPC, 32'h2004, n + 1});
      wq.push_back('{MCAUSE, 32'h2, n + 2});
      @(posedge clk); #1;
      ifc.trap_req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      ifc.req_valid = 1'b0;
      @(negedge clk);
      chk("abort_ready_rst", 32'(ifc.req_ready), 32'd0);
      chk("abort_wr_rst", 32'(ifc.csr_wr), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("abort_ready_rel", 32'(ifc.req_ready), 32'd1);
      repeat (8) @(posedge clk);
      drained("abort");
      chk("abort_mtval", mem[MTVAL], 32'h0);
      chk("abort_mstatus", mem[MSTATUS], 32'h1888);
      chk("abort_mscratch", mem[12'h340], 32'h5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
